// File: rtl/matrix_mult_vector_test.sv
// rtl/matrix_mult_vector_test.sv - free-running counter vector times constant matrix, registered result
// Optional MMV_OUT_REG_EN adds a product register stage (2-cycle latency instead of 1).
module matrix_mult_vector_test #(
  parameter int data_width = 2,
  parameter int n_columns  = 2,
  parameter int m_rows     = 2,
  localparam int CW = n_columns * data_width,
  localparam int RW = 2 * data_width + 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [RW*m_rows-1:0] outp,
  output logic [CW-1:0]        outp_inps
);

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [RW*m_rows-1:0]   outp_q, outp_d;
  logic [2*data_width-1:0] prod_d [m_rows][n_columns];
  logic [2*data_width-1:0] prod_sum_src [m_rows][n_columns];
  logic [RW-1:0]          sum;

  // Coefficients wrap modulo 2^data_width, so only the low bits are kept.
  function automatic logic [data_width-1:0] coef(input int r, input int c);
    int s;
    s = r * n_columns + c + 1;
    return s[data_width-1:0];
  endfunction

  assign cnt_d = cnt_q + CW'(1);

  always_comb begin
    for (int r = 0; r < m_rows; r++) begin
      for (int c = 0; c < n_columns; c++) begin
        prod_d[r][c] = {{data_width{1'b0}}, coef(r, c)} *
                       {{data_width{1'b0}}, cnt_q[c*data_width +: data_width]};
      end
    end
  end

`ifdef MMV_OUT_REG_EN
  logic [2*data_width-1:0] prod_q [m_rows][n_columns];

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '{default: '0};
    end else begin
      prod_q <= prod_d;
    end
  end

  assign prod_sum_src = prod_q;
`else
  assign prod_sum_src = prod_d;
`endif

  always_comb begin
    outp_d = '0;
    sum    = '0;
    for (int r = 0; r < m_rows; r++) begin
      sum = '0;
      for (int c = 0; c < n_columns; c++) begin
        sum = sum + {{(RW-2*data_width){1'b0}}, prod_sum_src[r][c]};
      end
      outp_d[r*RW +: RW] = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      outp_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      outp_q <= outp_d;
    end
  end

  assign outp      = outp_q;
  assign outp_inps = cnt_q;

endmodule

// File: tb/tb_matrix_mult_vector_test.sv
// tb/tb_matrix_mult_vector_test.sv - directed self-checking bench for matrix_mult_vector_test
module tb_matrix_mult_vector_test;

  localparam int RW = 36;
`ifdef MMV_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2*RW-1:0] outp;
  logic [3:0]    outp_inps;

  int errors = 0;
  int checks = 0;

  // A*v(k) for k = 0..15 with A = [[1,2],[3,0]], v(k) = (k[1:0], k[3:2]).
  logic [RW-1:0] row0_tbl [16] = '{0,1,2,3, 2,3,4,5, 4,5,6,7, 6,7,8,9};
  logic [RW-1:0] row1_tbl [16] = '{0,3,6,9, 0,3,6,9, 0,3,6,9, 0,3,6,9};

  logic [3:0]    exp_cnt;
  int            since_rst;
  logic [RW-1:0] exp_r0, exp_r1;

  matrix_mult_vector_test dut (
    .clk       (clk),
    .rst       (rst),
    .outp      (outp),
    .outp_inps (outp_inps)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic r);
    logic [3:0] idx;
    rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      exp_cnt   = 4'd0;
      since_rst = 0;
    end else begin
      exp_cnt   = exp_cnt + 4'd1;
      since_rst = since_rst + 1;
    end
    if (r || since_rst < LAT) begin
      exp_r0 = '0;
      exp_r1 = '0;
    end else begin
      idx    = exp_cnt - 4'(LAT);
      exp_r0 = row0_tbl[idx];
      exp_r1 = row1_tbl[idx];
    end
  endtask

  task automatic test_reset();
    tick(1'b1);
    tick(1'b1);
    checks++;
    if (outp_inps !== 4'd0) begin
      errors++;
      $display("FAIL reset_inps: got %0d want 0", outp_inps);
    end
    checks++;
    if (outp !== '0) begin
      errors++;
      $display("FAIL reset_outp: got %h want 0", outp);
    end
    tick(1'b0);
    checks++;
    if (outp_inps !== 4'd1) begin
      errors++;
      $display("FAIL reset_first_inps: got %0d want 1", outp_inps);
    end
    checks++;
    if (outp !== '0) begin
      errors++;
      $display("FAIL reset_first_outp: got %h want 0", outp);
    end
  endtask

  task automatic test_count();
    for (int i = 0; i < 5; i++) begin
      tick(1'b0);
      checks++;
      if (outp_inps !== exp_cnt) begin
        errors++;
        $display("FAIL count_inps: got %0d want %0d", outp_inps, exp_cnt);
      end
      checks++;
      if (outp[RW-1:0] !== exp_r0 || outp[2*RW-1:RW] !== exp_r1) begin
        errors++;
        $display("FAIL count_rows at inps=%0d: got %0d,%0d want %0d,%0d",
                 exp_cnt, outp[RW-1:0], outp[2*RW-1:RW], exp_r0, exp_r1);
      end
    end
    if (LAT == 1) begin
      checks++;
      if (outp[RW-1:0] !== 36'd3 || outp[2*RW-1:RW] !== 36'd3) begin
        errors++;
        $display("FAIL count_v5: got %0d,%0d want 3,3", outp[RW-1:0], outp[2*RW-1:RW]);
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      tick(1'b0);
      checks++;
      if (outp_inps !== exp_cnt) begin
        errors++;
        $display("FAIL wrap_inps: got %0d want %0d", outp_inps, exp_cnt);
      end
      checks++;
      if (outp[RW-1:0] !== exp_r0 || outp[2*RW-1:RW] !== exp_r1) begin
        errors++;
        $display("FAIL wrap_rows at inps=%0d: got %0d,%0d want %0d,%0d",
                 exp_cnt, outp[RW-1:0], outp[2*RW-1:RW], exp_r0, exp_r1);
      end
      if (exp_cnt == 4'd0 && LAT == 1) begin
        checks++;
        if (outp[RW-1:0] !== 36'd9 || outp[2*RW-1:RW] !== 36'd9) begin
          errors++;
          $display("FAIL wrap_v15: got %0d,%0d want 9,9", outp[RW-1:0], outp[2*RW-1:RW]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    while (exp_cnt != 4'd9 && guard < 32) begin
      tick(1'b0);
      guard++;
    end
    checks++;
    if (outp_inps !== 4'd9) begin
      errors++;
      $display("FAIL mid_pre_inps: got %0d want 9", outp_inps);
    end
    tick(1'b1);
    checks++;
    if (outp_inps !== 4'd0 || outp !== '0) begin
      errors++;
      $display("FAIL mid_reset: got inps=%0d outp=%h want 0,0", outp_inps, outp);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0);
      checks++;
      if (outp_inps !== exp_cnt || outp[RW-1:0] !== exp_r0 || outp[2*RW-1:RW] !== exp_r1) begin
        errors++;
        $display("FAIL mid_restart: got inps=%0d rows=%0d,%0d want inps=%0d rows=%0d,%0d",
                 outp_inps, outp[RW-1:0], outp[2*RW-1:RW], exp_cnt, exp_r0, exp_r1);
      end
    end
  endtask

  task automatic test_back_to_back_reset();
    tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    checks++;
    if (outp_inps !== 4'd0 || outp !== '0) begin
      errors++;
      $display("FAIL b2b_reset: got inps=%0d outp=%h want 0,0", outp_inps, outp);
    end
    tick(1'b0);
    tick(1'b0);
    checks++;
    if (outp_inps !== 4'd2 || outp[RW-1:0] !== exp_r0 || outp[2*RW-1:RW] !== exp_r1) begin
      errors++;
      $display("FAIL b2b_restart: got inps=%0d rows=%0d,%0d want inps=2 rows=%0d,%0d",
               outp_inps, outp[RW-1:0], outp[2*RW-1:RW], exp_r0, exp_r1);
    end
  endtask

  initial begin
    exp_cnt   = 4'd0;
    since_rst = 0;
    exp_r0    = '0;
    exp_r1    = '0;
    test_reset();
    test_count();
    test_wrap();
    test_mid_reset();
    test_back_to_back_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
